bcd_upcount_cascade: RTL and testbench

BCD_UPCOUNT_CASCADE -- requirements
Module: bcd_upcount_cascade

---
 rtl/bcd_upcount_cascade_if.sv | 24 ++
 rtl/bcd_upcount_cascade.sv | 71 +++++++
 tb/tb_bcd_upcount_cascade.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/bcd_upcount_cascade_if.sv
// Bus bundle for the cascadable BCD up-counter: control/load inputs and count/status outputs.
// The testbench or upstream logic uses the master side; the counter uses the slave side.
interface bcd_upcount_cascade_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  ci;
  logic                  ld;
  logic [4*DIGITS-1:0]   d;
  logic [4*DIGITS-1:0]   q;
  logic                  co;
  logic                  tc;
  logic                  err;

  modport master (
    output en, ci, ld, d,
    input  q, co, tc, err
  );

  modport slave (
    input  en, ci, ld, d,
    output q, co, tc, err
  );
endinterface

// File: rtl/bcd_upcount_cascade.sv
// Cascadable multi-digit BCD up-counter with synchronous reset, validated parallel load,
// registered wrap pulse (co), registered load-rejected pulse (err) and a combinational
// terminal count (tc) that can feed the ci of a downstream stage.
module bcd_upcount_cascade #(
  parameter int DIGITS = 4
) (
  input logic                  clk,
  input logic                  mr,
  bcd_upcount_cascade_if.slave bus
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0] count_q;
  logic [W-1:0] count_inc;
  logic         carry;
  logic         all_nines;
  logic         load_ok;
  logic         co_q;
  logic         err_q;

  // Decimal increment with ripple carry, all-9s detection and per-digit validity of the load value.
  always_comb begin
    count_inc = count_q;
    carry     = 1'b1;
    all_nines = 1'b1;
    load_ok   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (count_q[4*i +: 4] != 4'd9) begin
        all_nines = 1'b0;
      end
      if (bus.d[4*i +: 4] > 4'd9) begin
        load_ok = 1'b0;
      end
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // State update with priority reset, then load (valid or rejected), then count, then hold.
  always_ff @(posedge clk) begin
    if (mr) begin
      count_q <= '0;
      co_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (bus.ld) begin
      if (load_ok) begin
        count_q <= bus.d;
      end
      co_q  <= 1'b0;
      err_q <= ~load_ok;
    end else if (bus.en && bus.ci) begin
      count_q <= count_inc;
      co_q    <= all_nines;
      err_q   <= 1'b0;
    end else begin
      co_q  <= 1'b0;
      err_q <= 1'b0;
    end
  end

  assign bus.q   = count_q;
  assign bus.co  = co_q;
  assign bus.err = err_q;
  assign bus.tc  = all_nines & bus.en & bus.ci;
endmodule

// File: tb/tb_bcd_upcount_cascade.sv
// Self-checking bench for bcd_upcount_cascade: directed scenarios followed by randomized
// stimulus, compared against an integer-valued decimal reference model.
module tb_bcd_upcount_cascade;
  localparam int DIGITS    = 4;
  localparam int W         = 4 * DIGITS;
  localparam int MAX_COUNT = (10 ** DIGITS) - 1;

  logic clk;
  logic mr;

  int tests;
  int fails;

  int model_count;
  bit model_ready;
  bit exp_co;
  bit exp_err;

  bcd_upcount_cascade_if #(.DIGITS(DIGITS)) bus ();

  bcd_upcount_cascade #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .mr  (mr),
    .bus (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] b);
    int v;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v = v * 10 + int'(b[4*i +: 4]);
    end
    return v;
  endfunction

  function automatic bit bcd_valid(input logic [W-1:0] b);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit s_mr, input bit s_ld, input bit s_en, input bit s_ci,
                               input logic [W-1:0] s_d);
    mr     = s_mr;
    bus.ld = s_ld;
    bus.en = s_en;
    bus.ci = s_ci;
    bus.d  = s_d;
    #1;
    if (model_ready) begin
      checkOutput("tc", 32'(bus.tc), 32'((model_count == MAX_COUNT) && s_en && s_ci));
    end
    @(posedge clk);
    if (s_mr) begin
      model_count = 0;
      exp_co      = 1'b0;
      exp_err     = 1'b0;
      model_ready = 1'b1;
    end else if (s_ld) begin
      if (bcd_valid(s_d)) model_count = from_bcd(s_d);
      exp_err = !bcd_valid(s_d);
      exp_co  = 1'b0;
    end else if (s_en && s_ci) begin
      exp_co      = (model_count == MAX_COUNT);
      model_count = (model_count + 1) % (MAX_COUNT + 1);
      exp_err     = 1'b0;
    end else begin
      exp_co  = 1'b0;
      exp_err = 1'b0;
    end
    #1;
    if (model_ready) begin
      checkOutput("q", 32'(bus.q), 32'(to_bcd(model_count)));
      checkOutput("co", 32'(bus.co), 32'(exp_co));
      checkOutput("err", 32'(bus.err), 32'(exp_err));
    end
  endtask

  // Directed scenarios, then randomized traffic biased toward wraps and rejected loads.
  initial begin
    logic [W-1:0] rd;
    bit r_mr, r_ld, r_en, r_ci;
    tests       = 0;
    fails       = 0;
    model_count = 0;
    model_ready = 1'b0;
    exp_co      = 1'b0;
    exp_err     = 1'b0;
    mr          = 1'b0;
    bus.ld      = 1'b0;
    bus.en      = 1'b0;
    bus.ci      = 1'b0;
    bus.d       = '0;
    @(posedge clk);
    #1;

    applyStimulus(1, 0, 0, 0, '0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 1, '0);

    applyStimulus(0, 1, 0, 0, to_bcd(9998));
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, '0);

    applyStimulus(0, 1, 0, 0, to_bcd(199));
    applyStimulus(0, 0, 1, 1, '0);
    applyStimulus(0, 0, 1, 0, '0);
    applyStimulus(0, 0, 1, 1, '0);

    applyStimulus(0, 1, 0, 0, to_bcd(42));
    applyStimulus(0, 1, 1, 1, 16'h12A4);
    applyStimulus(0, 1, 0, 0, 16'h5678);
    applyStimulus(0, 0, 0, 1, '0);

    applyStimulus(0, 1, 0, 0, to_bcd(9999));
    applyStimulus(1, 1, 1, 1, to_bcd(1234));

    applyStimulus(0, 1, 0, 0, to_bcd(9999));
    applyStimulus(0, 1, 1, 1, to_bcd(500));

    applyStimulus(0, 1, 0, 0, to_bcd(9999));
    applyStimulus(0, 1, 1, 1, 16'hF000);

    for (int n = 0; n < 400; n++) begin
      r_mr = ($urandom_range(0, 31) == 0);
      r_ld = ($urandom_range(0, 5) == 0);
      r_en = ($urandom_range(0, 3) != 0);
      r_ci = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        rd = to_bcd(MAX_COUNT - int'($urandom_range(0, 3)));
      end else begin
        rd = to_bcd(int'($urandom_range(0, MAX_COUNT)));
      end
      if ($urandom_range(0, 2) == 0) begin
        rd[4*$urandom_range(0, DIGITS - 1) +: 4] = 4'($urandom_range(10, 15));
      end
      applyStimulus(r_mr, r_ld, r_en, r_ci, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
